// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared constants, line typedef and PC helpers for the instruction fetch queue
package ifq_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int DEF_WORDS   = 4;
    localparam int DEF_XLEN    = 32;

    // Line vector for the default geometry; word 0 lives in the LSBs.
    typedef logic [DEF_WORDS*DEF_XLEN-1:0] line_t;

    // Wide enough for any supported XLEN; callers cast to/from their own width.
    typedef logic [63:0] addr_t;

    function automatic addr_t line_align(input addr_t pc, input int lb);
        addr_t mask;
        mask = addr_t'(lb) - 64'd1;
        return pc & ~mask;
    endfunction

    function automatic int word_ofs(input addr_t pc, input int words);
        addr_t idx;
        idx = (pc >> $clog2(INSTR_BYTES)) & (addr_t'(words) - 64'd1);
        return int'(idx);
    endfunction

endpackage

// File: rtl/ifq_line_buf.sv
// rtl/ifq_line_buf.sv - DEPTH-entry line storage with wrap-bit pointers
module ifq_line_buf #(
    parameter int DEPTH = 4,
    parameter int LW    = 128
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [LW-1:0]            i_line,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [LW-1:0]            o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [LW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (i_flush) begin
            wp_d = '0;
            rp_d = '0;
        end else begin
            if (i_push) wp_d = wp_q + PW'(1);
            if (i_pop)  rp_d = rp_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage is cleared on reset so the head mux reads zero before any fill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (i_push && !i_flush) begin
            mem_q[wp_q[AW-1:0]] <= i_line;
        end
    end

    // The wrap bit makes the pointer difference span 0..DEPTH directly.
    assign o_count = wp_q - rp_q;
    assign o_full  = (o_count == PW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign o_head  = mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/ifq_param.sv
// rtl/ifq_param.sv - parametrised instruction fetch queue: line buffering, word delivery, redirect
module ifq_param
    import ifq_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              WORDS    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WORDS*XLEN-1:0]    i_line,
    input  logic                     i_line_valid,
    output logic                     o_fetch_req,
    output logic [XLEN-1:0]          o_fetch_pc,
    input  logic                     i_redirect,
    input  logic [XLEN-1:0]          i_redirect_pc,
    input  logic                     i_deq,
    output logic                     o_valid,
    output logic [XLEN-1:0]          o_instr,
    output logic [XLEN-1:0]          o_pc,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int OFS = $clog2(WORDS);
    localparam int LB  = WORDS * INSTR_BYTES;
    localparam int LW  = WORDS * XLEN;
    localparam logic [XLEN-1:0] RESET_FETCH = XLEN'(line_align(addr_t'(RESET_PC), LB));

    logic [OFS-1:0]  ofs_q, ofs_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            ovf_q, ovf_d;

    logic            full, empty;
    logic            push, pop, consume;
    logic [LW-1:0]   head;

    ifq_line_buf #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_line_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_line  (i_line),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .o_full  (full),
        .o_empty (empty),
        .o_count (o_count),
        .o_head  (head)
    );

    // Redirect dominates: it suppresses the write, the consume and the overflow pulse.
    always_comb begin
        push       = i_line_valid & ~full & ~i_redirect;
        consume    = i_deq & ~empty & ~i_redirect;
        pop        = consume & (ofs_q == OFS'(WORDS - 1));
        ovf_d      = i_line_valid & full & ~i_redirect;
        ofs_d      = ofs_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        if (i_redirect) begin
            ofs_d      = OFS'(word_ofs(addr_t'(i_redirect_pc), WORDS));
            pc_d       = {i_redirect_pc[XLEN-1:2], 2'b00};
            fetch_pc_d = XLEN'(line_align(addr_t'(i_redirect_pc), LB));
        end else begin
            if (push) fetch_pc_d = fetch_pc_q + XLEN'(LB);
            if (consume) begin
                pc_d  = pc_q + XLEN'(INSTR_BYTES);
                ofs_d = pop ? '0 : ofs_q + OFS'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ofs_q      <= '0;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_FETCH;
            ovf_q      <= 1'b0;
        end else begin
            ofs_q      <= ofs_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_valid     = ~empty;
    assign o_instr     = head[ofs_q*XLEN +: XLEN];
    assign o_pc        = pc_q;
    assign o_fetch_req = ~full;
    assign o_fetch_pc  = fetch_pc_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_ifq_param.sv
// tb/tb_ifq_param.sv - scoreboard bench for ifq_param in 4x4 and 8x8 geometries
module tb_ifq_param;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] a_line = '0;
    logic         a_lv = 0, a_redir = 0, a_deq = 0;
    logic [31:0]  a_rpc = '0;
    logic         a_req, a_valid, a_ovf;
    logic [31:0]  a_fpc, a_instr, a_pc;
    logic [2:0]   a_count;

    logic [255:0] b_line = '0;
    logic         b_lv = 0, b_redir = 0, b_deq = 0;
    logic [31:0]  b_rpc = '0;
    logic         b_req, b_valid, b_ovf;
    logic [31:0]  b_fpc, b_instr, b_pc;
    logic [3:0]   b_count;

    ifq_param u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_line(a_line), .i_line_valid(a_lv),
        .o_fetch_req(a_req), .o_fetch_pc(a_fpc), .i_redirect(a_redir), .i_redirect_pc(a_rpc),
        .i_deq(a_deq), .o_valid(a_valid), .o_instr(a_instr), .o_pc(a_pc),
        .o_count(a_count), .o_overflow(a_ovf)
    );

    ifq_param #(.DEPTH(8), .WORDS(8)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_line(b_line), .i_line_valid(b_lv),
        .o_fetch_req(b_req), .o_fetch_pc(b_fpc), .i_redirect(b_redir), .i_redirect_pc(b_rpc),
        .i_deq(b_deq), .o_valid(b_valid), .o_instr(b_instr), .o_pc(b_pc),
        .o_count(b_count), .o_overflow(b_ovf)
    );

    int passed = 0;
    int total  = 0;
    logic [63:0] sb_a[$];
    logic [63:0] sb_b[$];
    logic [63:0] e_a, e_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ K;
    endfunction

    task automatic set_line_a(input logic [31:0] addr, input int from);
        for (int w = 0; w < 4; w++) begin
            a_line[w*32 +: 32] = instr_of(addr + 32'(4*w));
            if (w >= from) sb_a.push_back({instr_of(addr + 32'(4*w)), addr + 32'(4*w)});
        end
    endtask

    task automatic set_line_b(input logic [31:0] addr, input int from);
        for (int w = 0; w < 8; w++) begin
            b_line[w*32 +: 32] = instr_of(addr + 32'(4*w));
            if (w >= from) sb_b.push_back({instr_of(addr + 32'(4*w)), addr + 32'(4*w)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a consume happens at the next edge when valid & deq & ~redirect.
    always @(negedge clk) begin
        if (rst_n && a_valid && a_deq && !a_redir) begin
            if (sb_a.size() == 0) check("a_sb_underflow", 64'd1, 64'd0);
            else begin
                e_a = sb_a.pop_front();
                check("a_instr", a_instr, e_a[63:32]);
                check("a_pc", a_pc, e_a[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_valid && b_deq && !b_redir) begin
            if (sb_b.size() == 0) check("b_sb_underflow", 64'd1, 64'd0);
            else begin
                e_b = sb_b.pop_front();
                check("b_instr", b_instr, e_b[63:32]);
                check("b_pc", b_pc, e_b[31:0]);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", a_valid, 0);
        check("rst_count", a_count, 0);
        check("rst_fetch_pc", a_fpc, 32'h0040_0000);
        check("rst_pc", a_pc, 32'h0040_0000);
        check("rst_instr", a_instr, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_req", a_req, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // single line, word-by-word delivery
        a_lv = 1; set_line_a(32'h0040_0000, 0); tick(); a_lv = 0;
        check("t1_valid", a_valid, 1);
        check("t1_instr0", a_instr, 32'h5A1A_0000);
        check("t1_pc0", a_pc, 32'h0040_0000);
        check("t1_fetch_pc", a_fpc, 32'h0040_0010);
        a_deq = 1; repeat (4) tick(); a_deq = 0;
        check("t1_empty", a_valid, 0);
        check("t1_pc_end", a_pc, 32'h0040_0010);

        // fill to full, overflow, drain across pointer wrap
        a_lv = 1;
        for (int i = 0; i < 4; i++) begin
            set_line_a(32'h0040_0010 + 32'(16*i), 0);
            tick();
        end
        check("t2_count_full", a_count, 4);
        check("t2_req_low", a_req, 0);
        check("t2_fetch_pc", a_fpc, 32'h0040_0050);
        a_line = '1; tick(); a_lv = 0;
        check("t2_ovf_pulse", a_ovf, 1);
        check("t2_count_hold", a_count, 4);
        tick();
        check("t2_ovf_clear", a_ovf, 0);
        check("t2_fetch_pc_hold", a_fpc, 32'h0040_0050);
        a_deq = 1; repeat (16) tick(); a_deq = 0;
        check("t2_drained", a_count, 0);

        // redirect with two lines queued, mid-line entry
        a_lv = 1;
        set_line_a(32'h0040_0050, 0); tick();
        set_line_a(32'h0040_0060, 0); tick();
        a_lv = 0;
        check("t3_count2", a_count, 2);
        a_redir = 1; a_rpc = 32'h0040_002B; sb_a.delete(); tick(); a_redir = 0;
        check("t3_count0", a_count, 0);
        check("t3_valid0", a_valid, 0);
        check("t3_fetch_pc", a_fpc, 32'h0040_0020);
        check("t3_pc", a_pc, 32'h0040_0028);
        a_lv = 1; set_line_a(32'h0040_0020, 2); tick(); a_lv = 0;
        check("t3_instr_w2", a_instr, 32'h5A1A_0028);
        check("t3_pc_w2", a_pc, 32'h0040_0028);
        a_deq = 1; repeat (2) tick(); a_deq = 0;
        check("t3_count_end", a_count, 0);
        check("t3_valid_end", a_valid, 0);

        // redirect + line + deq together while full
        a_lv = 1;
        for (int i = 0; i < 4; i++) begin
            set_line_a(32'h0040_0030 + 32'(16*i), 0);
            tick();
        end
        a_line = '1; a_deq = 1; a_redir = 1; a_rpc = 32'h0040_0104; sb_a.delete();
        tick();
        a_lv = 0; a_deq = 0; a_redir = 0;
        check("t4_count", a_count, 0);
        check("t4_no_ovf", a_ovf, 0);
        check("t4_pc", a_pc, 32'h0040_0104);
        check("t4_valid", a_valid, 0);
        check("t4_fetch_pc", a_fpc, 32'h0040_0100);
        check("t4_req", a_req, 1);
        tick();
        check("t4_no_ovf_late", a_ovf, 0);

        // steady stream: push coincident with last-word consume
        a_redir = 1; a_rpc = 32'h0040_0200; tick(); a_redir = 0;
        a_lv = 1; set_line_a(32'h0040_0200, 0); tick(); a_lv = 0;
        for (int l = 1; l <= 4; l++) begin
            for (int w = 0; w < 4; w++) begin
                a_deq = 1;
                a_lv = (w == 3);
                if (w == 3) set_line_a(32'h0040_0200 + 32'(16*l), 0);
                tick();
                check("t5_count1", a_count, 1);
                check("t5_valid1", a_valid, 1);
            end
        end
        a_lv = 0;
        repeat (4) tick();
        a_deq = 0;
        check("t5_count_end", a_count, 0);
        check("t5_fetch_pc", a_fpc, 32'h0040_0250);

        // 8x8 geometry: entry offset from bits [4:2]
        b_redir = 1; b_rpc = 32'h0040_0048; tick(); b_redir = 0;
        check("b_fetch_pc", b_fpc, 32'h0040_0040);
        check("b_pc", b_pc, 32'h0040_0048);
        b_lv = 1; set_line_b(32'h0040_0040, 2); tick(); b_lv = 0;
        check("b_instr_w2", b_instr, 32'h5A1A_0048);
        check("b_valid", b_valid, 1);
        for (int l = 1; l <= 2; l++) begin
            for (int w = (l == 1) ? 2 : 0; w < 8; w++) begin
                b_deq = 1;
                b_lv = (w == 7);
                if (w == 7) set_line_b(32'h0040_0040 + 32'(32*l), 0);
                tick();
                check("b_count1", b_count, 1);
                check("b_valid1", b_valid, 1);
            end
        end
        b_lv = 0;
        repeat (8) tick();
        b_deq = 0;
        check("b_count_end", b_count, 0);
        check("b_fetch_pc_end", b_fpc, 32'h0040_00A0);
        b_lv = 1;
        for (int i = 0; i < 8; i++) begin
            set_line_b(32'h0040_00A0 + 32'(32*i), 0);
            tick();
        end
        check("b_count_full", b_count, 8);
        check("b_req_low", b_req, 0);
        b_line = '1; tick(); b_lv = 0;
        check("b_ovf_pulse", b_ovf, 1);
        tick();
        check("b_ovf_clear", b_ovf, 0);
        check("b_count_hold", b_count, 8);
        b_deq = 1; repeat (64) tick(); b_deq = 0;
        check("b_drained", b_count, 0);
        check("a_sb_drained", sb_a.size(), 0);
        check("b_sb_drained", sb_b.size(), 0);

        // asynchronous reset mid-stream
        a_lv = 1;
        set_line_a(32'h0040_0250, 0); tick();
        set_line_a(32'h0040_0260, 0); tick();
        a_lv = 0;
        a_deq = 1; tick(); a_deq = 0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", a_valid, 0);
        check("ar_count", a_count, 0);
        check("ar_fetch_pc", a_fpc, 32'h0040_0000);
        check("ar_pc", a_pc, 32'h0040_0000);
        check("ar_b_fetch_pc", b_fpc, 32'h0040_0000);
        sb_a.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("ar_req", a_req, 1);
        a_lv = 1; set_line_a(32'h0040_0000, 0); tick(); a_lv = 0;
        a_deq = 1; repeat (4) tick(); a_deq = 0;
        check("ar_resume_fetch_pc", a_fpc, 32'h0040_0010);
        check("ar_sb_drained", sb_a.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ifq_param.md
Name: ifq_param

Overview:
- Parametrised instruction fetch queue; successor to the fixed 4-line/4-word IFQ.
- Buffers whole cache lines returned by the I-cache and hands single instructions with their PC to decode.
- Generates the line-aligned fetch PC toward the I-cache.
- Supports redirect (jump/branch) to any word-aligned target, including mid-line entry, with flush of queued and in-flight lines.

Parameters:
- DEPTH, 4, number of lines stored; power of 2, ≥2.
- WORDS, 4, 32-bit instructions per line; power of 2, ≥2.
- XLEN, 32, PC and instruction width.
- RESET_PC, 32'h0040_0000, PC after reset.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_line  in  WORDS*XLEN  line data from I-cache; word 0 in the LSBs.
- i_line_valid  in  1  i_line valid this cycle.
- o_fetch_req  out  1  queue can accept a line (not full).
- o_fetch_pc  out  XLEN  line-aligned address of the next line to fetch.
- i_redirect  in  1  jump/branch taken.
- i_redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored.
- i_deq  in  1  decode consumes o_instr this cycle.
- o_valid  out  1  o_instr/o_pc valid.
- o_instr  out  XLEN  current instruction.
- o_pc  out  XLEN  PC of o_instr.
- o_count  out  $clog2(DEPTH)+1  lines held.
- o_overflow  out  1  one-cycle pulse: line arrived while full (line dropped).

Behaviour:
- Interface: one clock, i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values:
  - count=0; write pointer = 0; read pointer = 0; word offset = 0.
  - fetch_pc = RESET_PC aligned down to a line boundary.
  - pc = RESET_PC.
  - o_valid=0; o_overflow=0; o_instr=0 (muxed from zeroed storage).
- Line size: LB = WORDS*4 bytes. OFS = log2(WORDS) word-offset bits, taken from PC[OFS+1:2].
- Pointers are $clog2(DEPTH)+1 bits wide, with a wrap bit.
  - full: count==DEPTH.
  - empty: count==0.
- Write: i_line_valid & ~full & ~i_redirect.
  - Line stored at wp; wp++.
  - fetch_pc += LB (modulo 2^XLEN).
- Overflow: i_line_valid & full → line dropped; o_overflow=1 next cycle only. State is otherwise unchanged.
- Output path (combinational from registered state):
  - o_valid = ~empty.
  - o_instr = word[offset] of line[rp].
  - o_pc = pc register.
- Consume: i_deq & o_valid.
  - pc += 4.
  - If offset==WORDS-1: rp++, offset=0, count--.
  - Otherwise offset++.
- i_deq while empty: ignored, no state change.
- Write and last-word consume in the same cycle: count unchanged; both pointers advance.
- Write latency: a line accepted in cycle N produces o_valid=1 in cycle N+1. There is no bypass.
- Redirect (highest priority; overrides a write and a consume in the same cycle), next cycle:
  - count=0; rp=wp=0.
  - offset = i_redirect_pc[OFS+1:2].
  - pc = {i_redirect_pc[XLEN-1:2],2'b00}.
  - fetch_pc = i_redirect_pc aligned down to LB.
  - Any i_line_valid in the redirect cycle is discarded. No o_overflow pulse.
- Mid-line entry: the first line after a redirect is delivered starting from the entry offset. Words below that offset are never presented.
- Stale-line rule: the cache must not return pre-redirect lines after the redirect cycle. A line returned after redirect is the target line.
- o_fetch_req = ~full. It is held during a redirect cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Outputs are valid from the first clock after deassertion.

Decomposition:
- Package ifq_pkg:
  - INSTR_BYTES=4.
  - function line_align(pc, LB).
  - function word_ofs(pc, WORDS).
  - typedef for the line vector.
- One sub-module, ifq_line_buf: DEPTH×(WORDS*XLEN) register array with wp/rp/count.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, count, head line.
- ifq_param holds: offset/pc/fetch_pc registers, redirect priority, word mux, overflow pulse.

Test Plan:
- Reset, then one line {I3,I2,I1,I0} with RESET_PC=0x400000 → next cycle o_valid=1, o_instr=I0, o_pc=0x400000. Four i_deq cycles → I1..I3 with o_pc stepping +4; then o_valid=0; fetch_pc=0x400010.
- Push 4 lines with no deq → o_count=4, o_fetch_req=0. 5th i_line_valid → o_overflow pulses 1 cycle; o_count stays 4. Drain all 16 words in order across wrap-around.
- Redirect to 0x400028 while 2 lines are queued → next cycle o_count=0, o_valid=0, fetch_pc=0x400020. Next line returned → o_instr=word2, o_pc=0x400028. Two deqs finish the line; o_count goes to 0.
- Same cycle i_redirect=1, i_line_valid=1, i_deq=1 → line discarded, no overflow, o_count=0, pc=redirect target.
- Steady stream: line push coincident with last-word deq → o_count constant at 1, o_valid never drops, PCs contiguous. Repeat with DEPTH=8, WORDS=8: LB=32, entry offset from bits [4:2].
- Assert i_rst_n low mid-stream → o_valid=0, o_count=0, fetch_pc=RESET_PC aligned, with no clock edge needed.
